// File: rtl/seq_pkg.sv
// Shared definitions for the 3-bit symbol stream (generator, detector, benches).
package seq_pkg;

  localparam int unsigned SYM_W = 3;
  localparam logic [SYM_W-1:0] IDLE_SYM = 3'b111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StGap  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/seq_pattern_ram.sv
// Pattern store: DEPTH x SYM_W register file, synchronous write, asynchronous read.
module seq_pattern_ram
  import seq_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [SYM_W-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [SYM_W-1:0] rdata_o
);

  logic [SYM_W-1:0] mem_q [DEPTH];
  logic [SYM_W-1:0] mem_d [DEPTH];

  // Next contents: only the addressed slot changes on a write.
  always_comb begin
    mem_d = mem_q;
    if (we_i) mem_d[waddr_i] = wdata_i;
  end

  // Slot storage; reset fills every slot with the idle symbol.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= IDLE_SYM;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sequence_generator.sv
// Replays a programmed symbol pattern rep_count times with gap_len idle symbols
// between repetitions. All outputs are registered.
module sequence_generator
  import seq_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [SYM_W-1:0] cfg_wdata,
  input  logic [AW:0]      seq_len,
  input  logic [CNT_W-1:0] rep_count,
  input  logic [CNT_W-1:0] gap_len,
  input  logic             start,
  input  logic             abort,
  output logic [SYM_W-1:0] data,
  output logic             data_valid,
  output logic             busy,
  output logic             done
);

  localparam logic [AW:0] MaxLen = (AW+1)'(DEPTH);

  seq_state_e state_q, state_d;

  logic [AW-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [AW:0]      len_q, len_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [CNT_W-1:0] gap_len_q, gap_len_d;

  logic [SYM_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             done_evt;
  logic             cfg_wr;
  logic [AW:0]      len_clamped;
  logic             last_sym;
  logic             last_rep;
  logic [SYM_W-1:0] rd_data;
  logic [SYM_W-1:0] sym_next;

  // Pattern writes are only honoured while idle.
  assign cfg_wr = cfg_we && (state_q == StIdle);

  seq_pattern_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we_i    (cfg_wr),
    .waddr_i (cfg_addr),
    .wdata_i (cfg_wdata),
    .raddr_i (idx_d),
    .rdata_o (rd_data)
  );

  // Decode helpers: clamped launch length and end-of-repetition conditions.
  always_comb begin
    len_clamped = (seq_len > MaxLen) ? MaxLen : seq_len;
    last_sym    = ({1'b0, idx_q} == (len_q - (AW+1)'(1)));
    last_rep    = (({1'b0, rep_q} + (CNT_W+1)'(1)) == {1'b0, rep_cnt_q});
  end

  // Next-state and counter logic.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rep_d     = rep_q;
    gap_d     = gap_q;
    len_d     = len_q;
    rep_cnt_d = rep_cnt_q;
    gap_len_d = gap_len_q;
    done_evt  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d     = len_clamped;
          rep_cnt_d = rep_count;
          gap_len_d = gap_len;
          idx_d     = '0;
          rep_d     = '0;
          gap_d     = '0;
          if ((len_clamped == '0) || (rep_count == '0)) begin
            done_evt = 1'b1;
          end else begin
            state_d = StSend;
          end
        end
      end
      StSend: begin
        if (last_sym) begin
          idx_d = '0;
          rep_d = rep_q + CNT_W'(1);
          if (last_rep) begin
            state_d  = StIdle;
            done_evt = 1'b1;
          end else if (gap_len_q != '0) begin
            state_d = StGap;
            gap_d   = CNT_W'(1);
          end
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      StGap: begin
        // gap_q numbers the idle symbol currently on the output (1..gap_len).
        if (gap_q == gap_len_q) begin
          state_d = StSend;
        end else begin
          gap_d = gap_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort beats everything, including a same-cycle start.
    if (abort) begin
      state_d  = StIdle;
      idx_d    = '0;
      rep_d    = '0;
      gap_d    = '0;
      done_evt = 1'b0;
    end
  end

  // A same-cycle write is visible to the symbol fetched at launch.
  always_comb begin
    sym_next = rd_data;
    if (cfg_wr && (cfg_addr == idx_d)) sym_next = cfg_wdata;
  end

  // Output next-values, derived from the state being entered.
  always_comb begin
    valid_d = (state_d == StSend);
    busy_d  = (state_d != StIdle);
    data_d  = valid_d ? sym_next : IDLE_SYM;
    done_d  = done_evt;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters, latched launch parameters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q     <= '0;
      rep_q     <= '0;
      gap_q     <= '0;
      len_q     <= '0;
      rep_cnt_q <= '0;
      gap_len_q <= '0;
      data_q    <= IDLE_SYM;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      rep_q     <= rep_d;
      gap_q     <= gap_d;
      len_q     <= len_d;
      rep_cnt_q <= rep_cnt_d;
      gap_len_q <= gap_len_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
